// File: rtl/ct_piu_l2pmp_apb_bridge.sv
// Purpose : bridge 32-bit APB transfers on the L2PMP port onto 64-bit piu_regs operations,
//           with lo-half write staging, a hi-half read capture, index range checking and a timeout.
// Latency : local transfers (lo write, hi read, range error) respond 1 cycle after the access phase;
//           register operations respond 1 cycle after regs_piu_cmplt, or TIMEOUT+1 cycles after sel.
// Backpressure: APB is held with pready low until the transfer resolves; one transfer in flight.
//
// Ports:
//   forever_cpuclk, cpurst                 clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata_l2pmp_x   APB request side
//   pready/perr_l2pmp_x, x_prdata_l2pmp    APB response side (zero outside the pready cycle)
//   piu_regs_sel/op/wr/wdata               one-cycle register request, op is the one-hot index
//   regs_piu_cmplt, regs_piu_rdata         register unit completion and 64-bit read data
//   piu_xx_regs_no_op                      high while the bridge is idle
module ct_piu_l2pmp_apb_bridge #(
  parameter int NUM_REG = 16,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 256
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              psel_l2pmp_x,
  input  logic              penable_l2pmp_x,
  input  logic              pwrite_l2pmp_x,
  input  logic [ADDR_W-1:0] paddr_l2pmp_x,
  input  logic [31:0]       pwdata_l2pmp_x,
  input  logic              regs_piu_cmplt,
  input  logic [63:0]       regs_piu_rdata,
  output logic              pready_l2pmp_x,
  output logic              perr_l2pmp_x,
  output logic [31:0]       x_prdata_l2pmp,
  output logic              piu_regs_sel,
  output logic [NUM_REG-1:0] piu_regs_op,
  output logic              piu_regs_wr,
  output logic [63:0]       piu_regs_wdata,
  output logic              piu_xx_regs_no_op
);

  localparam int IDX_W = ADDR_W - 3;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [31:0]      NUM_REG_U = NUM_REG;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic [63:0]      wdata_q;
  logic [31:0]      stage_lo;
  logic [31:0]      cap_hi;
  logic [31:0]      resp_data;
  logic             resp_err;
  logic [CNT_W-1:0] cnt;

  // Byte-lane bits carry no meaning for 32-bit accesses.
  logic unused_paddr;
  assign unused_paddr = ^paddr_l2pmp_x[1:0];

  logic             access;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_hi;
  logic             acc_oob;

  assign access  = psel_l2pmp_x & penable_l2pmp_x;
  assign acc_idx = paddr_l2pmp_x[ADDR_W-1:3];
  assign acc_hi  = paddr_l2pmp_x[2];
  assign acc_oob = (32'(acc_idx) >= NUM_REG_U);

  // State register
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt         = state;
    pready_l2pmp_x    = 1'b0;
    perr_l2pmp_x      = 1'b0;
    x_prdata_l2pmp    = 32'd0;
    piu_regs_sel      = 1'b0;
    piu_regs_op       = '0;
    piu_regs_wr       = 1'b0;
    piu_regs_wdata    = 64'd0;
    piu_xx_regs_no_op = 1'b0;

    case (state)
      IDLE: begin
        piu_xx_regs_no_op = 1'b1;
        if (access) begin
          // Only hi writes and lo reads need the register unit; everything else answers locally.
          if (!acc_oob && (pwrite_l2pmp_x == acc_hi)) begin
            state_nxt = REQ;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      REQ: begin
        piu_regs_sel   = 1'b1;
        piu_regs_wr    = wr_q;
        piu_regs_wdata = wr_q ? wdata_q : 64'd0;
        for (int i = 0; i < NUM_REG; i++) begin
          piu_regs_op[i] = (idx_q == IDX_W'(i));
        end
        state_nxt = regs_piu_cmplt ? RESP : WAIT;
      end
      WAIT: begin
        if (regs_piu_cmplt || (cnt == CNT_LAST)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        pready_l2pmp_x = 1'b1;
        perr_l2pmp_x   = resp_err;
        x_prdata_l2pmp = resp_data;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: staging, capture, latched request and response, wait counter
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= 64'd0;
      stage_lo  <= 32'd0;
      cap_hi    <= 32'd0;
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            // Response data stays 0 unless a read path fills it, so writes return 0.
            resp_err  <= 1'b0;
            resp_data <= 32'd0;
            if (acc_oob) begin
              resp_err <= 1'b1;
            end else if (pwrite_l2pmp_x && !acc_hi) begin
              stage_lo <= pwdata_l2pmp_x;
            end else if (pwrite_l2pmp_x) begin
              idx_q   <= acc_idx;
              wr_q    <= 1'b1;
              wdata_q <= {pwdata_l2pmp_x, stage_lo};
            end else if (!acc_hi) begin
              idx_q <= acc_idx;
              wr_q  <= 1'b0;
            end else begin
              resp_data <= cap_hi;
            end
          end
        end
        REQ: begin
          cnt <= '0;
          if (regs_piu_cmplt && !wr_q) begin
            cap_hi    <= regs_piu_rdata[63:32];
            resp_data <= regs_piu_rdata[31:0];
          end
        end
        WAIT: begin
          if (regs_piu_cmplt) begin
            if (!wr_q) begin
              cap_hi    <= regs_piu_rdata[63:32];
              resp_data <= regs_piu_rdata[31:0];
            end
          end else if (cnt == CNT_LAST) begin
            // Timed out: cap_hi keeps its old value; a late completion lands in IDLE/RESP and is dropped.
            resp_err  <= 1'b1;
            resp_data <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_piu_l2pmp_apb_bridge.sv
// Purpose : randomized scoreboard bench for ct_piu_l2pmp_apb_bridge against a register-file model.
// Latency : expected response latency is measured from the first access-phase cycle.
// Backpressure: the APB driver holds each transfer until pready, bounded by a cycle budget.
module tb_ct_piu_l2pmp_apb_bridge;
  localparam int NUM_REG = 16;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic              cmplt;
  logic [63:0]       rdata;
  logic              pready, perr;
  logic [31:0]       prdata;
  logic              sel;
  logic [NUM_REG-1:0] op;
  logic              wr;
  logic [63:0]       wdata;
  logic              no_op;

  ct_piu_l2pmp_apb_bridge #(.NUM_REG(NUM_REG), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .forever_cpuclk   (clk),
    .cpurst           (rst),
    .psel_l2pmp_x     (psel),
    .penable_l2pmp_x  (penable),
    .pwrite_l2pmp_x   (pwrite),
    .paddr_l2pmp_x    (paddr),
    .pwdata_l2pmp_x   (pwdata),
    .regs_piu_cmplt   (cmplt),
    .regs_piu_rdata   (rdata),
    .pready_l2pmp_x   (pready),
    .perr_l2pmp_x     (perr),
    .x_prdata_l2pmp   (prdata),
    .piu_regs_sel     (sel),
    .piu_regs_op      (op),
    .piu_regs_wr      (wr),
    .piu_regs_wdata   (wdata),
    .piu_xx_regs_no_op(no_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected APB responses and expected register operations.
  typedef struct {
    logic        err;
    logic [31:0] data;
    int          start;
    int          lat;
  } resp_t;

  typedef struct {
    logic [15:0] oh;
    logic        wr;
    logic [63:0] wdata;
    int          k;      // completion delay after sel; -1 = never (late pulse later), -2 = never
    logic [63:0] rdata;
  } op_t;

  resp_t rq[$];
  op_t   oq[$];

  // Reference model: register unit contents plus the bridge's architectural staging state.
  logic [63:0] mem [NUM_REG];
  logic [31:0] m_stage;
  logic [31:0] m_cap;

  // Issue one APB transfer; k is the register unit completion delay for operations.
  task automatic xfer(input logic [ADDR_W-1:0] addr, input logic w, input logic [31:0] d, input int k);
    int          idx;
    logic        hi;
    resp_t       e;
    op_t         o;
    logic [63:0] r;
    int          n;
    idx = int'(addr[ADDR_W-1:3]);
    hi  = addr[2];
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = addr; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    e.start = cyc;
    e.err   = 1'b0;
    e.data  = 32'd0;
    e.lat   = 1;
    if (idx >= NUM_REG) begin
      e.err = 1'b1;
    end else if (w && !hi) begin
      m_stage = d;
    end else if (!w && hi) begin
      e.data = m_cap;
    end else begin
      o.oh    = 16'h1 << idx;
      o.wr    = w;
      o.k     = k;
      o.wdata = w ? {d, m_stage} : 64'd0;
      r       = mem[idx];
      o.rdata = r;
      oq.push_back(o);
      if (k >= 0) begin
        e.lat = 2 + k;
        if (w) mem[idx] = {d, m_stage};
        else begin
          e.data = r[31:0];
          m_cap  = r[63:32];
        end
      end else begin
        e.lat = 2 + TIMEOUT;
        e.err = 1'b1;
      end
    end
    rq.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (pready) break;
      n++;
      if (n > 2 * TIMEOUT + 20) begin
        chk("pready_wait", 64'(n), 64'(2 * TIMEOUT + 20));
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Register unit responder: checks each request and answers after the planned delay.
  initial begin
    op_t o;
    cmplt = 1'b0;
    rdata = 64'd0;
    forever begin
      @(negedge clk);
      if (sel && !rst) begin
        if (oq.size() == 0) begin
          chk("unexpected_sel", 64'(sel), 64'd0);
        end else begin
          o = oq.pop_front();
          chk("regs_op", 64'(op), 64'(o.oh));
          chk("regs_wr", 64'(wr), 64'(o.wr));
          if (o.wr) chk("regs_wdata", wdata, o.wdata);
          if (o.k == 0) begin
            cmplt = 1'b1; rdata = o.rdata;
            @(posedge clk); #1;
            cmplt = 1'b0; rdata = {$urandom, $urandom};
          end else if (o.k > 0) begin
            repeat (o.k) @(posedge clk);
            #1; cmplt = 1'b1; rdata = o.rdata;
            @(posedge clk); #1;
            cmplt = 1'b0; rdata = {$urandom, $urandom};
          end else if (o.k == -1) begin
            // Late completion after the timeout response, carrying junk data.
            repeat (TIMEOUT + 2) @(posedge clk);
            #1; cmplt = 1'b1; rdata = {$urandom, $urandom};
            @(posedge clk); #1;
            cmplt = 1'b0;
          end
        end
      end
    end
  end

  // APB response monitor.
  initial begin
    resp_t e;
    logic  prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pready) begin
          chk("pready_back_to_back", 64'(prev_rdy), 64'd0);
          chk("no_op_during_resp", 64'(no_op), 64'd0);
          if (rq.size() == 0) begin
            chk("unexpected_pready", 64'(pready), 64'd0);
          end else begin
            e = rq.pop_front();
            chk("perr", 64'(perr), 64'(e.err));
            chk("prdata", 64'(prdata), 64'(e.data));
            chk("latency", 64'(cyc - e.start), 64'(e.lat));
          end
        end else begin
          chk("perr_idle", 64'(perr), 64'd0);
          chk("prdata_idle", 64'(prdata), 64'd0);
        end
        prev_rdy = pready;
      end else begin
        prev_rdy = 1'b0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pready"}, 64'(pready), 64'd0);
    chk({tag, "_perr"},   64'(perr),   64'd0);
    chk({tag, "_prdata"}, 64'(prdata), 64'd0);
    chk({tag, "_sel"},    64'(sel),    64'd0);
    chk({tag, "_op"},     64'(op),     64'd0);
    chk({tag, "_wr"},     64'(wr),     64'd0);
    chk({tag, "_wdata"},  wdata,       64'd0);
    chk({tag, "_no_op"},  64'(no_op),  64'd1);
  endtask

  initial begin
    op_t o;
    int  idx, k;
    logic hi, w;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = 32'd0;
    m_stage = 32'd0; m_cap = 32'd0;
    for (int i = 0; i < NUM_REG; i++) mem[i] = {$urandom, $urandom};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Lo/hi write pair to register 2.
    xfer(12'h010, 1'b1, 32'hDEAD_BEEF, 0);
    xfer(12'h014, 1'b1, 32'h1234_5678, 1);
    // Lo read then hi read of register 3.
    mem[3] = 64'hAAAA_BBBB_CCCC_DDDD;
    xfer(12'h018, 1'b0, 32'd0, 2);
    xfer(12'h01C, 1'b0, 32'd0, 0);
    chk("cap_hi_direct", 64'(m_cap), 64'hAAAA_BBBB);
    // Out-of-range index must not disturb stage_lo.
    xfer(12'h008, 1'b1, 32'h5555_0001, 0);
    xfer(12'h080, 1'b1, 32'h9999_9999, 0);
    xfer(12'h080, 1'b0, 32'd0, 0);
    xfer(12'h00C, 1'b1, 32'h0BAD_F00D, 0);
    // Timeout on a lo read, late completion ignored, then normal traffic.
    xfer(12'h020, 1'b0, 32'd0, -1);
    xfer(12'h024, 1'b0, 32'd0, 0);
    xfer(12'h028, 1'b0, 32'd0, 3);
    // Completion in the same cycle as sel.
    xfer(12'h030, 1'b0, 32'd0, 0);
    xfer(12'h034, 1'b0, 32'd0, 0);

    // Reset while waiting on the register unit.
    xfer(12'h040, 1'b1, 32'h7777_1111, 0);
    o.oh = 16'h1 << 9; o.wr = 1'b0; o.wdata = 64'd0; o.k = -2; o.rdata = 64'd0;
    oq.push_back(o);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h048;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rq.delete();
    oq.delete();
    m_stage = 32'd0;
    m_cap   = 32'd0;
    xfer(12'h04C, 1'b1, 32'hCAFE_0000, 1);
    xfer(12'h04C, 1'b0, 32'd0, 0);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      idx = $urandom_range(0, NUM_REG + 1);
      hi  = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      k   = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));
      xfer(ADDR_W'((idx << 3) | (int'(hi) << 2) | int'($urandom_range(0, 3))), w, $urandom, k);
    end

    repeat (TIMEOUT + 8) @(posedge clk);
    chk("resp_queue_drained", 64'(rq.size()), 64'd0);
    chk("op_queue_drained", 64'(oq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_piu_l2pmp_apb_bridge.md
# ct_piu_l2pmp_apb_bridge

Live replacement for the tied-off L2PMP APB slave and register-port stub in the PIU. It accepts 32-bit APB transfers on the L2PMP port and converts them into 64-bit register operations on the piu_regs handshake, with hi/lo staging, address-range checking and a completion timeout. Errors are reported on perr_l2pmp_x. The block sits between the APB fabric and the L2 register unit.

## Interface
Parameters:
- NUM_REG, 16: number of 64-bit registers; legal range 1..2^(ADDR_W-3), maximum 16.
- ADDR_W, 12: APB address width.
- TIMEOUT, 256: maximum number of cycles to wait for regs_piu_cmplt; must be ≥ 2. The counter width is clog2(TIMEOUT).

Ports:
- forever_cpuclk  in  1  clock; the only clock in the block.
- cpurst  in  1  synchronous, active-high reset.
- psel_l2pmp_x  in  1  APB select.
- penable_l2pmp_x  in  1  APB enable (access phase).
- pwrite_l2pmp_x  in  1  1 = write, 0 = read.
- paddr_l2pmp_x  in  ADDR_W  byte address. [2] selects the half (0 = lo, 1 = hi). [ADDR_W-1:3] is the register index. [1:0] is ignored.
- pwdata_l2pmp_x  in  32  write data.
- regs_piu_cmplt  in  1  register unit completion pulse.
- regs_piu_rdata  in  64  read data; valid with regs_piu_cmplt.
- pready_l2pmp_x  out  1  APB ready.
- perr_l2pmp_x  out  1  APB error; valid only while pready_l2pmp_x = 1, otherwise 0.
- x_prdata_l2pmp  out  32  read data; valid only while pready_l2pmp_x = 1 on a read, otherwise 0.
- piu_regs_sel  out  1  single-cycle register operation request.
- piu_regs_op  out  NUM_REG  one-hot register index, qualified by piu_regs_sel; 0 otherwise.
- piu_regs_wr  out  1  1 = write operation, qualified by piu_regs_sel.
- piu_regs_wdata  out  64  write data, qualified by piu_regs_sel & piu_regs_wr.
- piu_xx_regs_no_op  out  1  1 when no register operation is in flight (state IDLE).

## Operation
- State machine states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - No action when psel & penable = 0.
  - On psel & penable = 1 (first access-phase cycle), decode the transfer:
    - Index ≥ NUM_REG: set err, go to RESP. No register operation is issued.
    - Lo write: stage_lo ← pwdata, go to RESP with err = 0. No operation is issued.
    - Hi write: latch index and wdata = {pwdata, stage_lo}, wr = 1, go to REQ.
    - Lo read: latch index, wr = 0, go to REQ.
    - Hi read: return cap_hi, go to RESP. No operation is issued.
- REQ:
  - piu_regs_sel = 1 and piu_regs_op = one-hot of the latched index, for exactly one cycle.
  - Wait counter ← 0.
  - If regs_piu_cmplt = 1 in this cycle, go directly to RESP; otherwise go to WAIT.
- WAIT:
  - On regs_piu_cmplt: for a read, cap_hi ← rdata[63:32] and the response data ← rdata[31:0]; go to RESP with err = 0.
  - Otherwise the counter increments. When the counter = TIMEOUT-1 without completion, go to RESP with err = 1 and read data = 0. cap_hi is unchanged.
- RESP:
  - pready = 1 for one cycle, with perr and prdata driven from the latched values.
  - Next state is IDLE.
- regs_piu_cmplt is ignored in IDLE and RESP. A late completion after a timeout has no effect.
- stage_lo and cap_hi persist across transfers. A hi write with no preceding lo write uses the current stage_lo, which is 0 after reset.
- Reset:
  - State goes to IDLE.
  - stage_lo, cap_hi, counter and latched response are all cleared to 0.
  - Outputs: pready 0, perr 0, prdata 0, sel 0, op 0, wr 0, wdata 0, piu_xx_regs_no_op 1.
  - A reset asserted mid-transfer abandons it. No response is given.

## Timing
- Cycle 1 is the first access-phase cycle.
- Locally completed transfer (lo write, hi read, range error): pready in cycle 2.
- Register operation: sel in cycle 2. With completion at cycle 2+k (k ≥ 0), pready is at cycle 3+k for k ≥ 1, and at cycle 3 for k = 0.
- Timeout: if sel is at cycle 2, pready with err is at cycle 3+TIMEOUT.
- The APB master holds paddr, pwrite and pwdata stable through the access phase. The bridge samples them in cycle 1 only.
- The bridge never asserts pready for two consecutive cycles.
- piu_xx_regs_no_op = 0 from cycle 2 (REQ, WAIT or RESP) until the cycle after pready.

## Test plan
- Write 0xDEAD_BEEF to 0x010 (register 2, lo), then 0x1234_5678 to 0x014 (register 2, hi) -> the first transfer has pready in cycle 2 with no sel. The second transfer gives sel = 1, op = 0x0004, wr = 1, wdata = 0x1234_5678_DEAD_BEEF. With cmplt 1 cycle later, pready follows 1 cycle after cmplt with perr = 0.
- Read 0x018 (register 3, lo) with cmplt two cycles after sel and rdata = 0xAAAA_BBBB_CCCC_DDDD -> prdata = 0xCCCC_DDDD. A following read of 0x01C gives pready in cycle 2, prdata = 0xAAAA_BBBB, and no sel.
- Access index 16 (0x080) with NUM_REG = 16 -> pready in cycle 2, perr = 1, no sel, and stage_lo unchanged.
- Lo read with no cmplt -> pready with perr = 1 and prdata = 0 exactly TIMEOUT+1 cycles after sel. A cmplt injected afterward has no effect, and the next transfer proceeds normally.
- cmplt asserted in the same cycle as sel -> pready in the next cycle, with the correct read data captured.
- Assert cpurst while in WAIT -> the next cycle shows all outputs at reset values with piu_xx_regs_no_op = 1. A subsequent hi write then uses stage_lo = 0.
